// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch queue: instruction word, prediction bundle,
// queue entry layout and the stale-response FSM states.
package fetch_queue_pkg;

    typedef logic [31:0] rv32i_word;

    localparam rv32i_word RV32I_NOP = 32'h00000013;

    // Branch-prediction bundle carried alongside each fetched word
    typedef struct packed {
        logic      taken;
        logic [1:0] bht;
        rv32i_word target;
    } predict_regs;

    typedef struct packed {
        rv32i_word   pc;
        rv32i_word   instr;
        predict_regs predict;
    } fq_entry_t;

    typedef enum logic {
        FQ_NORMAL,
        FQ_DROP
    } fq_state_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle for the fetch queue.
// master = fetch + decode side, slave = the queue itself.
interface fetch_queue_if
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
);
    logic                   enq_valid;
    rv32i_word              enq_pc;
    rv32i_word              enq_instr;
    predict_regs            enq_predict;
    logic                   req_outstanding;
    logic                   flush;
    logic                   full;
    logic                   deq_ready;
    logic                   deq_valid;
    rv32i_word              deq_pc;
    rv32i_word              deq_instr;
    predict_regs            deq_predict;
    logic [$clog2(DEPTH):0] count;

    modport master (
        output enq_valid, enq_pc, enq_instr, enq_predict, req_outstanding, flush, deq_ready,
        input  full, deq_valid, deq_pc, deq_instr, deq_predict, count
    );

    modport slave (
        input  enq_valid, enq_pc, enq_instr, enq_predict, req_outstanding, flush, deq_ready,
        output full, deq_valid, deq_pc, deq_instr, deq_predict, count
    );
endinterface

// File: rtl/fetch_queue_mem.sv
// Entry storage: one write port, one asynchronous read port, no reset.
module fetch_queue_mem
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  fq_entry_t                wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output fq_entry_t                rdata
);
    fq_entry_t mem [DEPTH];

    // Write the addressed entry; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode. Circular buffer with
// head/tail/count, flush on redirect, and a DROP state that discards the
// one stale response still in flight after a flush.
// Optional macro FETCH_QUEUE_BYPASS_EN: an empty queue forwards the incoming
// word straight to decode in the same cycle when decode is ready.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int        DEPTH    = 4,
    parameter rv32i_word NOP_WORD = RV32I_NOP
) (
    input logic          clk,
    input logic          reset,
    fetch_queue_if.slave q
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head, tail;
    logic [CW-1:0] count_r;
    fq_state_t     state, state_nxt;
    fq_entry_t     rdata, wdata;
    logic          full_r, vld, byp, enq_fire, wr, deq_fire;

    assign full_r = (count_r == CW'(DEPTH));
    assign vld    = (count_r != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign byp = vld == 1'b0 && state == FQ_NORMAL && q.enq_valid && !q.flush && q.deq_ready;
`else
    assign byp = 1'b0;
`endif

    assign enq_fire = q.enq_valid && !full_r && state == FQ_NORMAL && !q.flush;
    // A bypassed word is consumed directly and never stored
    assign wr       = enq_fire && !byp;
    assign deq_fire = vld && q.deq_ready && !q.flush;

    assign wdata = '{pc: q.enq_pc, instr: q.enq_instr, predict: q.enq_predict};

    fetch_queue_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (wr),
        .waddr (tail),
        .wdata (wdata),
        .raddr (head),
        .rdata (rdata)
    );

    // Pointers and occupancy; flush wins over any enqueue/dequeue
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count_r <= '0;
        end else if (q.flush) begin
            head    <= '0;
            tail    <= '0;
            count_r <= '0;
        end else begin
            if (wr)       tail <= tail + PW'(1);
            if (deq_fire) head <= head + PW'(1);
            if (wr && !deq_fire)      count_r <= count_r + CW'(1);
            else if (!wr && deq_fire) count_r <= count_r - CW'(1);
        end
    end

    // Stale-response FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FQ_NORMAL;
        else       state <= state_nxt;
    end

    // Enter DROP only when a response is still owed; a same-cycle response
    // is already discarded by the flush itself
    always_comb begin
        state_nxt = state;
        case (state)
            FQ_NORMAL: if (q.flush && q.req_outstanding && !q.enq_valid) state_nxt = FQ_DROP;
            FQ_DROP:   if (!q.flush && q.enq_valid) state_nxt = FQ_NORMAL;
            default:   state_nxt = FQ_NORMAL;
        endcase
    end

    // Head presentation; NOP and zeros when nothing valid is on offer
    always_comb begin
        q.deq_valid   = vld;
        q.deq_pc      = '0;
        q.deq_instr   = NOP_WORD;
        q.deq_predict = '0;
        if (byp) begin
            q.deq_valid   = 1'b1;
            q.deq_pc      = q.enq_pc;
            q.deq_instr   = q.enq_instr;
            q.deq_predict = q.enq_predict;
        end else if (vld) begin
            q.deq_pc      = rdata.pc;
            q.deq_instr   = rdata.instr;
            q.deq_predict = rdata.predict;
        end
    end

    assign q.full  = full_r;
    assign q.count = count_r;
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: expected entries are queued when the
// bench drives a response it expects to be kept and popped at dequeue.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_queue_if #(.DEPTH(4)) q();

    fetch_queue #(.DEPTH(4), .NOP_WORD(RV32I_NOP)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (q)
    );

    int        checks = 0;
    int        passed = 0;
    bit        chk_full = 1'b1;
    fq_entry_t sb[$];
    fq_entry_t hd, e;

    // Fetch must never present a response while the queue is full
    always @(posedge clk) begin
        if (chk_full && !reset)
            assert (!(q.enq_valid && q.full)) else $error("FAIL enq_while_full");
    end

    function automatic fq_entry_t mk(input rv32i_word pc);
        fq_entry_t r;
        r.pc             = pc;
        r.instr          = 32'h00000033 | (pc << 7);
        r.predict.taken  = pc[2];
        r.predict.bht    = pc[3:2];
        r.predict.target = pc + 32'h40;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        q.enq_valid       = 1'b0;
        q.flush           = 1'b0;
        q.req_outstanding = 1'b0;
        q.deq_ready       = 1'b0;
    endtask

    task automatic drive(input fq_entry_t d);
        q.enq_valid   = 1'b1;
        q.enq_pc      = d.pc;
        q.enq_instr   = d.instr;
        q.enq_predict = d.predict;
    endtask

    task automatic test_reset();
        idle();
        q.enq_pc = '0; q.enq_instr = '0; q.enq_predict = '0;
        reset = 1'b1;
        step(); step();
        checks++;
        if ({q.deq_valid, q.full, q.count} !== 5'b0)
            $display("FAIL reset_flags: valid=%b full=%b count=%0d exp 0/0/0", q.deq_valid, q.full, q.count);
        else passed++;
        checks++;
        if ({q.deq_pc, q.deq_instr, q.deq_predict} !== {32'h0, RV32I_NOP, 35'h0})
            $display("FAIL reset_deq: pc=%h instr=%h pred=%h exp 0/00000013/0", q.deq_pc, q.deq_instr, q.deq_predict);
        else passed++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_order();
        for (int i = 0; i < 3; i++) begin
            e = mk(32'h60 + 32'(i * 4));
            sb.push_back(e);
            drive(e);
            step();
        end
        idle();
        checks++;
        if ({q.count, q.full, q.deq_pc} !== {3'd3, 1'b0, 32'h60})
            $display("FAIL order_fill: count=%0d full=%b pc=%h exp 3/0/60", q.count, q.full, q.deq_pc);
        else passed++;
        q.deq_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            hd = sb.pop_front();
            checks++;
            if ({q.deq_valid, q.deq_pc, q.deq_instr, q.deq_predict} !== {1'b1, hd})
                $display("FAIL order_head: pc=%h instr=%h exp pc=%h instr=%h", q.deq_pc, q.deq_instr, hd.pc, hd.instr);
            else passed++;
            step();
        end
        idle();
        checks++;
        if ({q.deq_valid, q.deq_instr, q.count} !== {1'b0, RV32I_NOP, 3'd0})
            $display("FAIL order_empty: valid=%b instr=%h count=%0d exp 0/00000013/0", q.deq_valid, q.deq_instr, q.count);
        else passed++;
    endtask

    task automatic test_full_wrap();
        for (int i = 0; i < 4; i++) begin
            e = mk(32'(i * 4));
            sb.push_back(e);
            drive(e);
            step();
        end
        idle();
        checks++;
        if ({q.full, q.count} !== {1'b1, 3'd4})
            $display("FAIL full_set: full=%b count=%0d exp 1/4", q.full, q.count);
        else passed++;
        chk_full = 1'b0;
        drive(mk(32'h10));
        step();
        idle();
        chk_full = 1'b1;
        checks++;
        if ({q.full, q.count} !== {1'b1, 3'd4})
            $display("FAIL full_drop: full=%b count=%0d exp 1/4", q.full, q.count);
        else passed++;
        hd = sb.pop_front();
        q.deq_ready = 1'b1;
        checks++;
        if ({q.deq_valid, q.deq_pc, q.deq_instr, q.deq_predict} !== {1'b1, hd})
            $display("FAIL full_head: pc=%h exp pc=%h", q.deq_pc, hd.pc);
        else passed++;
        step();
        idle();
        // Two simultaneous enq/deq at count 3 push the tail across the wrap
        for (int k = 0; k < 2; k++) begin
            e = mk(32'h14 + 32'(k * 4));
            sb.push_back(e);
            drive(e);
            q.deq_ready = 1'b1;
            hd = sb.pop_front();
            checks++;
            if ({q.deq_valid, q.deq_pc, q.deq_instr, q.deq_predict} !== {1'b1, hd})
                $display("FAIL simul_head: pc=%h exp pc=%h", q.deq_pc, hd.pc);
            else passed++;
            step();
            idle();
            checks++;
            if (q.count !== 3'd3)
                $display("FAIL simul_count: count=%0d exp 3", q.count);
            else passed++;
        end
        q.deq_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            hd = sb.pop_front();
            checks++;
            if ({q.deq_valid, q.deq_pc, q.deq_instr, q.deq_predict} !== {1'b1, hd})
                $display("FAIL wrap_head: pc=%h exp pc=%h", q.deq_pc, hd.pc);
            else passed++;
            step();
        end
        idle();
        checks++;
        if ({q.deq_valid, q.count} !== {1'b0, 3'd0})
            $display("FAIL wrap_empty: valid=%b count=%0d exp 0/0", q.deq_valid, q.count);
        else passed++;
    endtask

    task automatic test_flush_drop();
        for (int i = 0; i < 2; i++) begin
            drive(mk(32'h80 + 32'(i * 4)));
            step();
        end
        idle();
        q.flush = 1'b1;
        q.req_outstanding = 1'b1;
        step();
        idle();
        sb.delete();
        checks++;
        if ({q.deq_valid, q.count} !== {1'b0, 3'd0})
            $display("FAIL flush_clear: valid=%b count=%0d exp 0/0", q.deq_valid, q.count);
        else passed++;
        drive(mk(32'h100));
        step();
        idle();
        checks++;
        if (q.count !== 3'd0)
            $display("FAIL drop_stale: count=%0d exp 0", q.count);
        else passed++;
        e = mk(32'h200);
        sb.push_back(e);
        drive(e);
        step();
        idle();
        hd = sb.pop_front();
        checks++;
        if ({q.count, q.deq_valid, q.deq_pc, q.deq_instr, q.deq_predict} !== {3'd1, 1'b1, hd})
            $display("FAIL drop_next: count=%0d pc=%h exp 1/%h", q.count, q.deq_pc, hd.pc);
        else passed++;
        q.deq_ready = 1'b1;
        step();
        idle();
    endtask

    task automatic test_flush_enq();
        drive(mk(32'h300));
        step();
        q.flush = 1'b1;
        q.req_outstanding = 1'b1;
        drive(mk(32'h304));
        step();
        idle();
        checks++;
        if ({q.deq_valid, q.count} !== {1'b0, 3'd0})
            $display("FAIL flush_enq: valid=%b count=%0d exp 0/0", q.deq_valid, q.count);
        else passed++;
        e = mk(32'h308);
        sb.push_back(e);
        drive(e);
        step();
        idle();
        hd = sb.pop_front();
        checks++;
        if ({q.count, q.deq_valid, q.deq_pc, q.deq_instr, q.deq_predict} !== {3'd1, 1'b1, hd})
            $display("FAIL flush_enq_next: count=%0d pc=%h exp 1/%h", q.count, q.deq_pc, hd.pc);
        else passed++;
        q.deq_ready = 1'b1;
        step();
        idle();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            drive(mk(32'h500 + 32'(i * 4)));
            step();
        end
        idle();
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({q.deq_valid, q.full, q.count, q.deq_instr} !== {1'b0, 1'b0, 3'd0, RV32I_NOP})
            $display("FAIL async_rst_fill: valid=%b full=%b count=%0d instr=%h exp 0/0/0/00000013",
                     q.deq_valid, q.full, q.count, q.deq_instr);
        else passed++;
        step();
        reset = 1'b0;
        step();
        // Enter DROP, then reset mid-cycle: must come back in NORMAL
        q.flush = 1'b1;
        q.req_outstanding = 1'b1;
        step();
        idle();
        #3 reset = 1'b1;
        #1 reset = 1'b0;
        step();
        e = mk(32'h600);
        sb.push_back(e);
        drive(e);
        step();
        idle();
        hd = sb.pop_front();
        checks++;
        if ({q.count, q.deq_valid, q.deq_pc, q.deq_instr, q.deq_predict} !== {3'd1, 1'b1, hd})
            $display("FAIL async_rst_drop: count=%0d pc=%h exp 1/%h", q.count, q.deq_pc, hd.pc);
        else passed++;
        q.deq_ready = 1'b1;
        step();
        idle();
    endtask

    task automatic test_bypass();
        e = mk(32'h40);
        drive(e);
        q.deq_ready = 1'b1;
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        checks++;
        if ({q.deq_valid, q.deq_pc, q.deq_instr, q.deq_predict} !== {1'b1, e})
            $display("FAIL bypass_same: valid=%b pc=%h exp 1/%h", q.deq_valid, q.deq_pc, e.pc);
        else passed++;
        step();
        idle();
        checks++;
        if ({q.deq_valid, q.count} !== {1'b0, 3'd0})
            $display("FAIL bypass_count: valid=%b count=%0d exp 0/0", q.deq_valid, q.count);
        else passed++;
`else
        checks++;
        if (q.deq_valid !== 1'b0)
            $display("FAIL no_bypass: valid=%b exp 0", q.deq_valid);
        else passed++;
        step();
        q.enq_valid = 1'b0;
        checks++;
        if ({q.count, q.deq_valid, q.deq_pc, q.deq_instr, q.deq_predict} !== {3'd1, 1'b1, e})
            $display("FAIL latency_one: count=%0d pc=%h exp 1/%h", q.count, q.deq_pc, e.pc);
        else passed++;
        step();
        idle();
        checks++;
        if (q.count !== 3'd0)
            $display("FAIL latency_drain: count=%0d exp 0", q.count);
        else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_order();
        test_full_wrap();
        test_flush_drop();
        test_flush_enq();
        test_async_reset();
        test_bypass();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
